// File: rtl/matrix_readback.sv
// matrix_readback -- host readback path of the Raspberry Pi <-> FPGA test-bench link.
// A capture rising edge freezes the 64 synchronised sense pins into a snapshot.
// The snapshot is then presented one byte at a time on RPI_DO. Each read_strobe
// falling edge advances to the next byte, and the eighth edge ends the readout.
// If the host goes quiet, a timeout aborts the readout.
//
// Ports:
//   clk_100mhz   in   system clock
//   rst_n        in   asynchronous active-low reset
//   sense_pin    in   [0:63] DUT sense pins (asynchronous)
//   capture      in   host capture request, rising edge snapshots
//   read_strobe  in   host read strobe, falling edge advances
//   RPI_DO       out  [0:7] byte to host, RPI_DO[0] = snapshot[8*byte_idx]
//   rpi_oe       out  bus-buffer drive enable toward host
//   ready        out  snapshot valid, readout in progress
//   LED          out  [0] toggles per completed readout, [1] sticky timeout
//
// state   | meaning
// IDLE    | bus released, waiting for a capture edge
// READOUT | snapshot presented, byte_idx selects the byte on RPI_DO

module matrix_readback #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic [0:63] sense_pin,
  input  logic        capture,
  input  logic        read_strobe,
  output logic [0:7]  RPI_DO,
  output logic        rpi_oe,
  output logic        ready,
  output logic [1:0]  LED
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_READOUT = 1'b1;

  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

  logic        r_cap_s1, r_cap_s2, r_cap_d3;
  logic        r_stb_s1, r_stb_s2, r_stb_d3;
  logic [0:63] r_pin_s1, r_pin_s2;
  logic [0:0]  r_state;
  logic [0:63] r_snap;
  logic [2:0]  r_byte_idx;
  logic [19:0] r_to_cnt;
  logic [1:0]  r_led;

  logic w_cap_rise;
  logic w_stb_fall;
  logic w_to_hit;

  assign w_cap_rise = r_cap_s2 & ~r_cap_d3;
  assign w_stb_fall = ~r_stb_s2 & r_stb_d3;
  assign w_to_hit   = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_s1   <= 1'b0;
      r_cap_s2   <= 1'b0;
      r_cap_d3   <= 1'b0;
      r_stb_s1   <= 1'b0;
      r_stb_s2   <= 1'b0;
      r_stb_d3   <= 1'b0;
      r_pin_s1   <= '0;
      r_pin_s2   <= '0;
      r_state    <= S_IDLE;
      r_snap     <= '0;
      r_byte_idx <= 3'd0;
      r_to_cnt   <= 20'd0;
      r_led      <= 2'b00;
    end else begin
      r_cap_s1 <= capture;
      r_cap_s2 <= r_cap_s1;
      r_cap_d3 <= r_cap_s2;
      r_stb_s1 <= read_strobe;
      r_stb_s2 <= r_stb_s1;
      r_stb_d3 <= r_stb_s2;
      r_pin_s1 <= sense_pin;
      r_pin_s2 <= r_pin_s1;

      // Capture has priority over everything else: a coincident strobe edge
      // or timeout is discarded, and a capture mid-readout restarts at byte 0.
      if (w_cap_rise) begin
        r_snap     <= r_pin_s2;
        r_byte_idx <= 3'd0;
        r_to_cnt   <= 20'd0;
        r_state    <= S_READOUT;
        r_led[1]   <= 1'b0;
      end else if (r_state == S_READOUT) begin
        if (w_stb_fall) begin
          r_to_cnt <= 20'd0;
          if (r_byte_idx == 3'd7) begin
            r_state  <= S_IDLE;
            r_led[0] <= ~r_led[0];
          end else begin
            r_byte_idx <= r_byte_idx + 3'd1;
          end
        end else if (w_to_hit) begin
          r_state  <= S_IDLE;
          r_led[1] <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 20'd1;
        end
      end
    end
  end

  // Outputs decode registered state only, so they move on clock edges
  // (or the asynchronous reset) and never glitch on input activity.
  always_comb begin
    RPI_DO = '0;
    rpi_oe = 1'b0;
    ready  = 1'b0;
    if (r_state == S_READOUT) begin
      RPI_DO = r_snap[{r_byte_idx, 3'b000} +: 8];
      rpi_oe = 1'b1;
      ready  = 1'b1;
    end
  end

  assign LED = r_led;

endmodule

// File: tb/tb_matrix_readback.sv
module tb_matrix_readback;

  logic        clk_100mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:63] sense_pin = '0;
  logic        capture = 1'b0;
  logic        read_strobe = 1'b0;
  logic [0:7]  RPI_DO;
  logic        rpi_oe;
  logic        ready;
  logic [1:0]  LED;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_full [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

  matrix_readback #(.TIMEOUT_CYCLES(100)) dut (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .sense_pin  (sense_pin),
    .capture    (capture),
    .read_strobe(read_strobe),
    .RPI_DO     (RPI_DO),
    .rpi_oe     (rpi_oe),
    .ready      (ready),
    .LED        (LED)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_100mhz);
      #1;
    end
  endtask

  task automatic pulse_capture();
    capture = 1'b1;
    step(4);
    capture = 1'b0;
    step(4);
  endtask

  task automatic pulse_strobe();
    read_strobe = 1'b1;
    step(4);
    read_strobe = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_vec++;
    if ({RPI_DO, rpi_oe, ready, LED} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_hold: got do=%h oe=%b rdy=%b led=%b, want all 0", RPI_DO, rpi_oe, ready, LED);
    end
    rst_n = 1'b1;
    step(2);
    n_vec++;
    if ({RPI_DO, rpi_oe, ready, LED} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_release: got do=%h oe=%b rdy=%b led=%b, want all 0", RPI_DO, rpi_oe, ready, LED);
    end
  endtask

  task automatic test_full_readout();
    sense_pin = 64'h0123_4567_89AB_CDEF;
    pulse_capture();
    n_vec++;
    if (ready !== 1'b1 || rpi_oe !== 1'b1) begin
      n_err++;
      $display("FAIL full_ready: got rdy=%b oe=%b, want 1 1", ready, rpi_oe);
    end
    n_vec++;
    if (RPI_DO !== exp_full[0]) begin
      n_err++;
      $display("FAIL full_byte0: got %h, want %h", RPI_DO, exp_full[0]);
    end
    for (int i = 1; i < 8; i++) begin
      pulse_strobe();
      n_vec++;
      if (RPI_DO !== exp_full[i]) begin
        n_err++;
        $display("FAIL full_byte%0d: got %h, want %h", i, RPI_DO, exp_full[i]);
      end
    end
    pulse_strobe();
    n_vec++;
    if (ready !== 1'b0 || rpi_oe !== 1'b0 || RPI_DO !== 8'h00 || LED !== 2'b01) begin
      n_err++;
      $display("FAIL full_end: got rdy=%b oe=%b do=%h led=%b, want 0 0 00 01", ready, rpi_oe, RPI_DO, LED);
    end
  endtask

  task automatic test_snapshot_hold();
    sense_pin = {8{8'hFF}};
    pulse_capture();
    sense_pin = '0;
    n_vec++;
    if (RPI_DO !== 8'hFF) begin
      n_err++;
      $display("FAIL hold_byte0: got %h, want ff", RPI_DO);
    end
    for (int i = 1; i < 8; i++) begin
      pulse_strobe();
      n_vec++;
      if (RPI_DO !== 8'hFF) begin
        n_err++;
        $display("FAIL hold_byte%0d: got %h, want ff", i, RPI_DO);
      end
    end
    pulse_strobe();
    n_vec++;
    if (ready !== 1'b0 || LED !== 2'b00) begin
      n_err++;
      $display("FAIL hold_end: got rdy=%b led=%b, want 0 00", ready, LED);
    end
  endtask

  task automatic test_recapture();
    sense_pin = 64'h0123_4567_89AB_CDEF;
    pulse_capture();
    repeat (3) pulse_strobe();
    n_vec++;
    if (RPI_DO !== 8'h67) begin
      n_err++;
      $display("FAIL recap_byte3: got %h, want 67", RPI_DO);
    end
    sense_pin = {8{8'hA5}};
    pulse_capture();
    n_vec++;
    if (RPI_DO !== 8'hA5 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL recap_restart: got do=%h rdy=%b, want a5 1", RPI_DO, ready);
    end
    pulse_strobe();
    sense_pin = 64'h0123_4567_89AB_CDEF;
    read_strobe = 1'b1;
    step(4);
    capture = 1'b1;
    read_strobe = 1'b0;
    step(4);
    capture = 1'b0;
    step(4);
    n_vec++;
    if (RPI_DO !== 8'h01) begin
      n_err++;
      $display("FAIL recap_simul: got %h, want 01", RPI_DO);
    end
    for (int i = 1; i < 8; i++) begin
      pulse_strobe();
      n_vec++;
      if (RPI_DO !== exp_full[i]) begin
        n_err++;
        $display("FAIL recap_byte%0d: got %h, want %h", i, RPI_DO, exp_full[i]);
      end
    end
    pulse_strobe();
    n_vec++;
    if (ready !== 1'b0 || LED !== 2'b01) begin
      n_err++;
      $display("FAIL recap_end: got rdy=%b led=%b, want 0 01", ready, LED);
    end
  endtask

  task automatic test_timeout();
    int t_rise;
    int t_fall;
    t_rise = -1;
    t_fall = -1;
    sense_pin = 64'h0123_4567_89AB_CDEF;
    capture = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      step(1);
      if (c == 4) capture = 1'b0;
      if (t_rise < 0) begin
        if (ready === 1'b1) t_rise = c;
      end else if (ready === 1'b0) begin
        t_fall = c;
        break;
      end
    end
    n_vec++;
    if (t_rise != 3) begin
      n_err++;
      $display("FAIL to_rise: got cycle %0d, want 3", t_rise);
    end
    n_vec++;
    if (t_fall < 0 || (t_fall - t_rise) != 100) begin
      n_err++;
      $display("FAIL to_len: got %0d cycles (fall=%0d), want 100", t_fall - t_rise, t_fall);
    end
    n_vec++;
    if (LED !== 2'b11 || rpi_oe !== 1'b0 || RPI_DO !== 8'h00) begin
      n_err++;
      $display("FAIL to_flags: got led=%b oe=%b do=%h, want 11 0 00", LED, rpi_oe, RPI_DO);
    end
    pulse_capture();
    n_vec++;
    if (LED !== 2'b01 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL to_clear: got led=%b rdy=%b, want 01 1", LED, ready);
    end
  endtask

  task automatic test_reset_mid();
    sense_pin = 64'h0123_4567_89AB_CDEF;
    pulse_capture();
    repeat (4) pulse_strobe();
    n_vec++;
    if (RPI_DO !== 8'h89) begin
      n_err++;
      $display("FAIL rstmid_byte4: got %h, want 89", RPI_DO);
    end
    @(posedge clk_100mhz);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({RPI_DO, rpi_oe, ready, LED} !== 12'h000) begin
      n_err++;
      $display("FAIL rstmid_async: got do=%h oe=%b rdy=%b led=%b, want all 0", RPI_DO, rpi_oe, ready, LED);
    end
    step(2);
    rst_n = 1'b1;
    step(2);
    repeat (8) pulse_strobe();
    n_vec++;
    if (ready !== 1'b0 || RPI_DO !== 8'h00 || rpi_oe !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_nocap: got rdy=%b do=%h oe=%b, want 0 00 0", ready, RPI_DO, rpi_oe);
    end
  endtask

  task automatic test_latency();
    sense_pin = 64'h0123_4567_89AB_CDEF;
    @(posedge clk_100mhz);
    #1;
    capture = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      n_vec++;
      if (ready !== (e == 3)) begin
        n_err++;
        $display("FAIL lat_cap_e%0d: got rdy=%b, want %b", e, ready, (e == 3));
      end
    end
    step(1);
    capture = 1'b0;
    step(4);
    read_strobe = 1'b1;
    step(4);
    n_vec++;
    if (RPI_DO !== 8'h01) begin
      n_err++;
      $display("FAIL lat_rise_ignored: got %h, want 01", RPI_DO);
    end
    read_strobe = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      n_vec++;
      if (RPI_DO !== ((e == 3) ? 8'h23 : 8'h01)) begin
        n_err++;
        $display("FAIL lat_stb_e%0d: got %h, want %h", e, RPI_DO, (e == 3) ? 8'h23 : 8'h01);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_readout();
    test_snapshot_hold();
    test_recapture();
    test_timeout();
    test_reset_mid();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
